// File: rtl/mmio_pkg.sv
// Shared address map, timer control-bit layout and decode region type for
// the data-side memory subsystem.
package mmio_pkg;

    localparam logic [31:0] GPIO_OUT_ADDR    = 32'hFFFF_0000;
    localparam logic [31:0] GPIO_IN_ADDR     = 32'hFFFF_0004;
    localparam logic [31:0] TIMER_COUNT_ADDR = 32'hFFFF_0010;
    localparam logic [31:0] TIMER_CMP_ADDR   = 32'hFFFF_0014;
    localparam logic [31:0] TIMER_CTRL_ADDR  = 32'hFFFF_0018;

    localparam int EN_BIT   = 0;
    localparam int PEND_BIT = 1;
    localparam int AR_BIT   = 2;

    localparam logic [31:0] TIMER_CMP_RESET = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_GPIO_OUT,
        SEL_GPIO_IN,
        SEL_TIMER,
        SEL_NONE
    } sel_e;

endpackage

// File: rtl/dmem_mmio_if.sv
// Processor data-port bus: single-cycle access, combinational read data.
interface dmem_mmio_if;
    logic        WE;
    logic [31:0] address_to_mem;
    logic [31:0] data_to_mem;
    logic [31:0] data_from_mem;

    modport master (output WE, output address_to_mem, output data_to_mem,
                    input  data_from_mem);
    modport slave  (input  WE, input  address_to_mem, input  data_to_mem,
                    output data_from_mem);
endinterface

// File: rtl/mmio_timer.sv
// 32-bit compare timer with optional autoreload and a sticky pending flag.
module mmio_timer
    import mmio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic        sel_count,
    input  logic        sel_cmp,
    input  logic        sel_ctrl,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [31:0] count_q, count_d;
    logic [31:0] cmp_q, cmp_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        match;

    always_comb begin
        match   = ctrl_q[EN_BIT] && (count_q == cmp_q);
        count_d = count_q;
        cmp_d   = cmp_q;
        ctrl_d  = ctrl_q;

        // A software load of COUNT always beats reload and increment.
        if (we && sel_count)
            count_d = wdata;
        else if (match && ctrl_q[AR_BIT])
            count_d = '0;
        else if (ctrl_q[EN_BIT])
            count_d = count_q + 32'd1;

        if (we && sel_cmp)
            cmp_d = wdata;

        if (we && sel_ctrl) begin
            ctrl_d[EN_BIT] = wdata[EN_BIT];
            ctrl_d[AR_BIT] = wdata[AR_BIT];
            if (wdata[PEND_BIT])
                ctrl_d[PEND_BIT] = 1'b0;
        end
        // Set has priority over a same-cycle write-1-to-clear.
        if (match)
            ctrl_d[PEND_BIT] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            cmp_q   <= TIMER_CMP_RESET;
            ctrl_q  <= '0;
        end else begin
            count_q <= count_d;
            cmp_q   <= cmp_d;
            ctrl_q  <= ctrl_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (sel_count)
            rdata = count_q;
        else if (sel_cmp)
            rdata = cmp_q;
        else if (sel_ctrl)
            rdata = {29'd0, ctrl_q};
    end

    assign irq = ctrl_q[PEND_BIT];

endmodule

// File: rtl/dmem_mmio.sv
// Data memory subsystem: word RAM plus a peripheral page (GPIO, timer),
// with sticky detection of accesses to unmapped addresses.
module dmem_mmio
    import mmio_pkg::*;
#(
    parameter int RAM_WORDS = 256,
    parameter int GPIO_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    dmem_mmio_if.slave        bus,
    output logic [GPIO_W-1:0] gpio_out,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic              timer_irq,
    output logic              bus_err
);

    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0]       addr_w;
    sel_e              sel;
    logic [AW-1:0]     ram_idx;
    logic [31:0]       ram_rdata;
    logic [31:0]       mem [RAM_WORDS];
    logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
    logic [GPIO_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic              bus_err_q, bus_err_d;
    logic              t_sel_count, t_sel_cmp, t_sel_ctrl;
    logic [31:0]       timer_rdata;
    logic [31:0]       gpio_out_ext, gpio_in_ext;
    logic [31:0]       rdata;

    assign addr_w  = bus.address_to_mem & ~32'h3;
    assign ram_idx = addr_w[AW+1:2];

    always_comb begin
        sel = SEL_NONE;
        if (addr_w[31:AW+2] == '0)
            sel = SEL_RAM;
        else begin
            case (addr_w)
                GPIO_OUT_ADDR:    sel = SEL_GPIO_OUT;
                GPIO_IN_ADDR:     sel = SEL_GPIO_IN;
                TIMER_COUNT_ADDR,
                TIMER_CMP_ADDR,
                TIMER_CTRL_ADDR:  sel = SEL_TIMER;
                default:          sel = SEL_NONE;
            endcase
        end
    end

    assign t_sel_count = (addr_w == TIMER_COUNT_ADDR);
    assign t_sel_cmp   = (addr_w == TIMER_CMP_ADDR);
    assign t_sel_ctrl  = (addr_w == TIMER_CTRL_ADDR);

    // The processor cannot stall, so RAM reads must be asynchronous.
    always_ff @(posedge clk) begin
        if (bus.WE && (sel == SEL_RAM) && !reset)
            mem[ram_idx] <= bus.data_to_mem;
    end
    assign ram_rdata = mem[ram_idx];

    always_comb begin
        gpio_out_d = gpio_out_q;
        if (bus.WE && (sel == SEL_GPIO_OUT))
            gpio_out_d = bus.data_to_mem[GPIO_W-1:0];
        sync1_d   = gpio_in;
        sync2_d   = sync1_q;
        bus_err_d = bus_err_q | (sel == SEL_NONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            gpio_out_q <= gpio_out_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            bus_err_q  <= bus_err_d;
        end
    end

    mmio_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .we        (bus.WE),
        .sel_count (t_sel_count),
        .sel_cmp   (t_sel_cmp),
        .sel_ctrl  (t_sel_ctrl),
        .wdata     (bus.data_to_mem),
        .rdata     (timer_rdata),
        .irq       (timer_irq)
    );

    always_comb begin
        gpio_out_ext               = '0;
        gpio_out_ext[GPIO_W-1:0]   = gpio_out_q;
        gpio_in_ext                = '0;
        gpio_in_ext[GPIO_W-1:0]    = sync2_q;
    end

    always_comb begin
        case (sel)
            SEL_RAM:      rdata = ram_rdata;
            SEL_GPIO_OUT: rdata = gpio_out_ext;
            SEL_GPIO_IN:  rdata = gpio_in_ext;
            SEL_TIMER:    rdata = timer_rdata;
            default:      rdata = '0;
        endcase
    end

    assign bus.data_from_mem = reset ? 32'd0 : rdata;
    assign gpio_out          = gpio_out_q;
    assign bus_err           = bus_err_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: a vector table for RAM/GPIO/register basics,
// then hand-written timer, unmapped-access and async-reset sequences.
module tb_dmem_mmio;

    localparam logic [31:0] A_GOUT  = 32'hFFFF_0000;
    localparam logic [31:0] A_GIN   = 32'hFFFF_0004;
    localparam logic [31:0] A_COUNT = 32'hFFFF_0010;
    localparam logic [31:0] A_CMP   = 32'hFFFF_0014;
    localparam logic [31:0] A_CTRL  = 32'hFFFF_0018;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] gpio_out;
    logic [7:0] gpio_in;
    logic       timer_irq;
    logic       bus_err;
    int         errors = 0;
    int         checks = 0;

    dmem_mmio_if bus ();

    dmem_mmio #(.RAM_WORDS(256), .GPIO_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .gpio_out  (gpio_out),
        .gpio_in   (gpio_in),
        .timer_irq (timer_irq),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[19];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else
            $display("ok   %s: %h", name, act);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.WE             = 1'b1;
        bus.address_to_mem = a;
        bus.data_to_mem    = d;
        @(posedge clk);
        #1;
        bus.WE             = 1'b0;
        bus.address_to_mem = 32'h0;
        $display("wr   %h <= %h", a, d);
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus.WE             = 1'b0;
        bus.address_to_mem = a;
        #1;
        chk32(name, bus.data_from_mem, exp);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 32'h0000_0044, 32'h1234_5678, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_0040, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b0, 32'h0000_0042, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b0, 32'h0000_0044, 32'h0,         1'b1, 32'h1234_5678};
        vecs[6]  = '{1'b1, 32'h0000_0044, 32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0044, 32'h0,         1'b1, 32'hCAFE_F00D};
        vecs[8]  = '{1'b1, 32'h0000_03FC, 32'hA1B2_C3D4, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 32'h0000_03FC, 32'h0,         1'b1, 32'hA1B2_C3D4};
        vecs[10] = '{1'b1, A_GOUT,        32'h0000_01A5, 1'b0, 32'h0};
        vecs[11] = '{1'b0, A_GOUT,        32'h0,         1'b1, 32'h0000_00A5};
        vecs[12] = '{1'b1, A_GIN,         32'h0000_00FF, 1'b0, 32'h0};
        vecs[13] = '{1'b0, A_GIN,         32'h0,         1'b1, 32'h0};
        vecs[14] = '{1'b0, A_CMP,         32'h0,         1'b1, 32'hFFFF_FFFF};
        vecs[15] = '{1'b0, A_COUNT,       32'h0,         1'b1, 32'h0};
        vecs[16] = '{1'b1, A_CTRL,        32'hFFFF_FFF8, 1'b0, 32'h0};
        vecs[17] = '{1'b0, A_CTRL,        32'h0,         1'b1, 32'h0};
        vecs[18] = '{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h1111_1111};

        reset              = 1'b1;
        bus.WE             = 1'b0;
        bus.address_to_mem = 32'h0;
        bus.data_to_mem    = 32'h0;
        gpio_in            = 8'h00;
        #12;
        chk32("rst_gpio_out",  {24'd0, gpio_out}, 32'h0);
        chk32("rst_irq",       {31'd0, timer_irq}, 32'h0);
        chk32("rst_bus_err",   {31'd0, bus_err}, 32'h0);
        chk32("rst_rdata",     bus.data_from_mem, 32'h0);
        step();
        reset = 1'b0;

        // Table: value read is checked before the edge; writes land at the edge.
        for (int i = 0; i < 19; i++) begin
            bus.WE             = vecs[i].we;
            bus.address_to_mem = vecs[i].addr;
            bus.data_to_mem    = vecs[i].wdata;
            #1;
            if (vecs[i].chk)
                chk32($sformatf("vec%0d_rd", i), bus.data_from_mem, vecs[i].exp);
            chk32($sformatf("vec%0d_berr", i), {31'd0, bus_err}, 32'h0);
            step();
            bus.WE = 1'b0;
        end
        chk32("gpio_out_pin", {24'd0, gpio_out}, 32'h0000_00A5);

        // GPIO input synchroniser: visible after the second edge.
        gpio_in = 8'h3C;
        rd("gin_edge0", A_GIN, 32'h0);
        step();
        rd("gin_edge1", A_GIN, 32'h0);
        step();
        rd("gin_edge2", A_GIN, 32'h3C);

        // Timer match without autoreload.
        wr(A_CMP, 32'd5);
        wr(A_COUNT, 32'd0);
        wr(A_CTRL, 32'h1);
        rd("tm_count0", A_COUNT, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            step();
            rd($sformatf("tm_count%0d", k), A_COUNT, k);
        end
        chk32("tm_irq_pre", {31'd0, timer_irq}, 32'h0);
        step();
        chk32("tm_irq_post", {31'd0, timer_irq}, 32'h1);
        rd("tm_count6", A_COUNT, 32'd6);
        rd("tm_ctrl_pend", A_CTRL, 32'h3);
        wr(A_CTRL, 32'h2);
        chk32("tm_irq_clr", {31'd0, timer_irq}, 32'h0);

        // Autoreload sequence 0,1,2,3,0,1 then clear race.
        wr(A_CMP, 32'd3);
        wr(A_COUNT, 32'd0);
        wr(A_CTRL, 32'h5);
        for (int i = 0; i < 6; i++) begin
            rd($sformatf("ar_seq%0d", i), A_COUNT, (i < 4) ? i : i - 4);
            if (i < 5)
                step();
        end
        chk32("ar_irq_set", {31'd0, timer_irq}, 32'h1);
        step();
        step();
        rd("ar_match_cycle", A_COUNT, 32'd3);
        wr(A_CTRL, 32'h7);
        chk32("race_set_wins", {31'd0, timer_irq}, 32'h1);
        rd("race_count0", A_COUNT, 32'd0);
        wr(A_CTRL, 32'h7);
        chk32("clear_nomatch", {31'd0, timer_irq}, 32'h0);
        rd("clear_count1", A_COUNT, 32'd1);
        step();
        chk32("clear_stays", {31'd0, timer_irq}, 32'h0);

        // Unmapped access.
        wr(32'h8000_0000, 32'h1234);
        chk32("berr_set", {31'd0, bus_err}, 32'h1);
        rd("unmapped_rd", 32'h8000_0000, 32'h0);
        step();
        chk32("berr_sticky", {31'd0, bus_err}, 32'h1);
        rd("no_alias_ram0", 32'h0, 32'h1111_1111);
        rd("past_ram_rd", 32'h0000_0400, 32'h0);

        // Async reset between edges while the timer runs.
        wr(A_GOUT, 32'hFF);
        chk32("gout_ff", {24'd0, gpio_out}, 32'h0000_00FF);
        step();
        bus.address_to_mem = 32'h40;
        #2;
        reset = 1'b1;
        #1;
        chk32("arst_gpio_out", {24'd0, gpio_out}, 32'h0);
        chk32("arst_irq",      {31'd0, timer_irq}, 32'h0);
        chk32("arst_bus_err",  {31'd0, bus_err}, 32'h0);
        chk32("arst_rdata",    bus.data_from_mem, 32'h0);
        bus.WE          = 1'b1;
        bus.data_to_mem = 32'h5555_5555;
        step();
        bus.WE = 1'b0;
        reset  = 1'b0;
        rd("arst_ram_kept", 32'h40, 32'hDEAD_BEEF);
        rd("arst_cmp", A_CMP, 32'hFFFF_FFFF);
        rd("arst_count_a", A_COUNT, 32'd0);
        step();
        rd("arst_count_b", A_COUNT, 32'd0);
        step();
        rd("arst_count_c", A_COUNT, 32'd0);
        wr(A_CTRL, 32'h1);
        rd("arst_en_count0", A_COUNT, 32'd0);
        step();
        rd("arst_en_count1", A_COUNT, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-side memory subsystem downstream of the single-cycle processor's data port. Consumes `WE`, `address_to_mem` and `data_to_mem`, and returns `data_from_mem` combinationally in the same cycle. The processor has no stall, so every access completes in one cycle. Decodes the address into a word RAM and a small memory-mapped peripheral page: GPIO out, synchronised GPIO in, and a 32-bit compare timer with a sticky interrupt flag.

## Interface
- `RAM_WORDS`, 256: RAM depth in 32-bit words; power of two, 16..65536.
- `GPIO_W`, 8: GPIO width, 1..32.
- `clk` in 1: single clock, all state on posedge.
- `reset` in 1: asynchronous, active-high; clears all registers below (RAM contents excluded).
- `WE` in 1: write strobe from processor.
- `address_to_mem` in 32: byte address; bits [1:0] ignored everywhere.
- `data_to_mem` in 32: store data.
- `data_from_mem` out 32: combinational read data; 0 while `reset` is high.
- `gpio_out` out GPIO_W: GPIO_OUT register; reset 0.
- `gpio_in` in GPIO_W: asynchronous external inputs.
- `timer_irq` out 1: timer pending flag; reset 0.
- `bus_err` out 1: sticky unmapped-access flag; reset 0; cleared only by `reset`.

## Operation
- Address map, word-aligned:
  - RAM at 0x0000_0000 .. RAM_WORDS*4-1, indexed by address[log2(RAM_WORDS)+1:2]. RAM is not reset.
  - GPIO_OUT 0xFFFF_0000, RW; unused upper bits read 0.
  - GPIO_IN 0xFFFF_0004, RO; writes ignored, no error.
  - TIMER_COUNT 0xFFFF_0010, RW.
  - TIMER_CMP 0xFFFF_0014, RW; reset 0xFFFF_FFFF.
  - TIMER_CTRL 0xFFFF_0018: bit0 EN, bit1 PEND (read; write 1 clears), bit2 AUTORELOAD; other bits read 0; reset 0.
- Any other address is unmapped. Reads of an unmapped address return 0. Reads or writes to it set `bus_err`; writes have no other effect.
- Reads are purely combinational from current state. Writes take effect at the posedge where `WE`=1.
- GPIO_IN is a two-flop synchroniser on `gpio_in`, zero-extended on read.
- Timer, evaluated every posedge:
  - Write to TIMER_COUNT loads `data_to_mem` and overrides the increment.
  - Else if EN and COUNT==CMP and AUTORELOAD: COUNT <= 0.
  - Else if EN: COUNT <= COUNT+1, wrapping 0xFFFF_FFFF -> 0.
  - Match event: EN=1 and COUNT==CMP, using pre-edge values. A match sets PEND.
  - A TIMER_CTRL write updates EN and AUTORELOAD. PEND is cleared if data bit1=1.
  - Match and clear in the same cycle: set wins, so PEND stays 1.
  - A TIMER_CMP write takes effect for the next cycle's compare.
- `timer_irq` = PEND.

## Timing
- Read latency 0 cycles: data is valid in the same cycle as the address.
- Write latency: the new value is readable in the cycle after the write edge.
- GPIO_IN latency: 2 clk edges from `gpio_in` change to read visibility.
- Timer match: PEND and `timer_irq` rise 1 cycle after the cycle in which COUNT==CMP.
- Reset asserted mid-operation:
  - All registers take reset values immediately, asynchronously.
  - A write in the reset cycle is discarded, including RAM writes (RAM write is gated by !reset).
  - Counting resumes on the first edge after deassertion only once EN has been written.

## Structure
- Shared package `mmio_pkg`:
  - address constants: GPIO_OUT_ADDR, GPIO_IN_ADDR, TIMER_COUNT_ADDR, TIMER_CMP_ADDR, TIMER_CTRL_ADDR;
  - CTRL bit indices EN_BIT, PEND_BIT, AR_BIT;
  - TIMER_CMP_RESET.
- Sub-module `mmio_timer` holds COUNT, CMP, CTRL, the match logic and the read mux.
- Top `dmem_mmio` holds the decode, RAM, GPIO registers, synchroniser, `bus_err` and the final read mux.

## Test plan
- RAM write/read:
  - Write 0xDEADBEEF to 0x0000_0040.
  - Next cycle, reading 0x40 and 0x42 both return 0xDEADBEEF.
  - Reading 0x44 returns the earlier value; `bus_err`=0.
- GPIO path:
  - Write 0x1A5 to GPIO_OUT -> `gpio_out`=0xA5 (GPIO_W=8).
  - Drive `gpio_in`=0x3C -> a GPIO_IN read returns 0x3C from the 2nd edge onward and the old value before that.
- Timer match:
  - Write CMP=5, COUNT=0, CTRL=0x1.
  - COUNT reads 5 in the 5th cycle after the CTRL write; `timer_irq`=1 one cycle later; COUNT then continues to 6.
- Autoreload and clear race:
  - Set CTRL=0x5, CMP=3.
  - COUNT sequence 0,1,2,3,0,1.
  - A CTRL write of 0x7 in a match cycle leaves `timer_irq`=1.
  - The same write in a non-match cycle clears it.
- Unmapped access:
  - Write 0x1234 to 0x8000_0000 -> `bus_err`=1 next cycle and stays 1; a read of that address returns 0.
- Async reset:
  - Assert `reset` between edges while the timer runs with `gpio_out`=0xFF.
  - Outputs drop to 0 immediately; CMP reads 0xFFFF_FFFF; COUNT stays 0 after release until EN is set.
